pr_vertex_engine: RTL and testbench

- Parametrised per-vertex PageRank compute core for the PageRank accelerator.
- Consumes a vertex stream of (in-degree, out-degree) pairs and a lane-parallel stream of already-fetched in-neighbour PageRank values.
- Accumulates the in-neighbour values per vertex, applies optional damping in fixed point, divides by out-degree with a sequential divider, and emits one write request (address, data) per vertex.
- Sits between the vertex/in-edge FIFOs and the AXI write channel, replacing the inline single-lane accumulate logic; counts vertices and pulses completion once per round.

---
 rtl/pr_vertex_engine.sv | 218 +++++++++++++++++++++
 tb/tb_pr_vertex_engine.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pr_vertex_engine.sv
// Per-vertex PageRank core: lane-parallel in-neighbour accumulation, optional
// fixed-point damping, restoring divide by out-degree, one write per vertex.
module pr_vertex_engine #(
   parameter int unsigned INT_W   = 64,
   parameter int unsigned FRAC_W  = 16,
   parameter int unsigned LANES   = 4,
   parameter bit          DAMP_EN = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [INT_W-1:0]         n_vertices,
   input  logic [63:0]              base_waddr,
   input  logic [INT_W-1:0]         damping,
   input  logic [INT_W-1:0]         teleport,
   input  logic                     vert_valid,
   input  logic [2*INT_W-1:0]       vert_data,
   output logic                     vert_ready,
   input  logic                     edge_valid,
   input  logic [LANES-1:0]         edge_mask,
   input  logic [LANES*INT_W-1:0]   edge_data,
   output logic                     edge_ready,
   output logic                     wr_valid,
   output logic [63:0]              wr_addr,
   output logic [INT_W-1:0]         wr_data,
   input  logic                     wr_ready,
   output logic                     busy,
   output logic                     round_done,
   output logic                     err_overflow
);

   localparam int unsigned CNT_W = $clog2(INT_W);
   localparam int unsigned BYTES = INT_W / 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_VERT,
      S_ACC,
      S_SCALE,
      S_DIV,
      S_WRITE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [INT_W-1:0] r_nvert;
   logic [63:0]      r_base;
   logic [INT_W-1:0] r_vcount;
   logic [INT_W-1:0] r_remaining;
   logic [INT_W-1:0] r_outdeg;
   logic [INT_W-1:0] r_sum;
   logic [INT_W-1:0] r_quot;
   logic [INT_W-1:0] r_rem;
   logic [CNT_W-1:0] r_div_cnt;
   logic [INT_W-1:0] r_wr_data;
   logic             r_round_done;
   logic             r_err;

   logic [INT_W-1:0] w_acc;
   logic [INT_W:0]   w_add;
   logic [INT_W-1:0] w_take;
   logic             w_sat;
   logic             w_excess;
   logic [INT_W-1:0] w_rem_next;
   logic [INT_W-1:0] w_scaled;
   logic [INT_W:0]   w_rem_sh;
   logic [INT_W:0]   w_diff;
   logic             w_qbit;
   logic [INT_W-1:0] w_rem_new;
   logic [INT_W-1:0] w_quot_new;
   logic             w_last;

   // Lanes are consumed in ascending order until the vertex's in-degree is used up
   always_comb begin
      w_acc    = r_sum;
      w_add    = '0;
      w_take   = '0;
      w_sat    = 1'b0;
      w_excess = 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (edge_mask[i]) begin
            if (w_take < r_remaining) begin
               w_add = {1'b0, w_acc} + {1'b0, edge_data[INT_W*i +: INT_W]};
               if (w_add[INT_W]) begin
                  w_acc = '1;
                  w_sat = 1'b1;
               end else begin
                  w_acc = w_add[INT_W-1:0];
               end
               w_take = w_take + INT_W'(1);
            end else begin
               w_excess = 1'b1;
            end
         end
      end
   end

   assign w_rem_next = r_remaining - w_take;

   generate
      if (DAMP_EN) begin : g_damp
         logic [2*INT_W-1:0] w_prod;
         logic [2*INT_W-1:0] w_tot;
         always_comb begin
            w_prod   = {{INT_W{1'b0}}, r_sum} * {{INT_W{1'b0}}, damping};
            w_tot    = (w_prod >> FRAC_W) + {{INT_W{1'b0}}, teleport};
            w_scaled = (|w_tot[2*INT_W-1:INT_W]) ? '1 : w_tot[INT_W-1:0];
         end
      end else begin : g_raw
         logic w_unused_damp;
         assign w_unused_damp = ^{damping, teleport};
         assign w_scaled      = r_sum;
      end
   endgenerate

   // Restoring divide step: the dividend shifts out of r_quot as quotient bits shift in
   assign w_rem_sh   = {r_rem, r_quot[INT_W-1]};
   assign w_diff     = w_rem_sh - {1'b0, r_outdeg};
   assign w_qbit     = ~w_diff[INT_W];
   assign w_rem_new  = w_qbit ? w_diff[INT_W-1:0] : w_rem_sh[INT_W-1:0];
   assign w_quot_new = {r_quot[INT_W-2:0], w_qbit};

   assign w_last = (r_vcount + INT_W'(1)) == r_nvert;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start && (n_vertices != '0)) w_next = S_VERT;
         S_VERT:  if (vert_valid)
                     w_next = (vert_data[2*INT_W-1:INT_W] != '0) ? S_ACC : S_SCALE;
         S_ACC:   if (edge_valid && (w_rem_next == '0)) w_next = S_SCALE;
         S_SCALE: w_next = (r_outdeg != '0) ? S_DIV : S_WRITE;
         S_DIV:   if (r_div_cnt == '0) w_next = S_WRITE;
         S_WRITE: if (wr_ready) w_next = w_last ? S_IDLE : S_VERT;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      vert_ready = 1'b0;
      edge_ready = 1'b0;
      wr_valid   = 1'b0;
      busy       = (r_state != S_IDLE);
      case (r_state)
         S_VERT:  vert_ready = 1'b1;
         S_ACC:   edge_ready = 1'b1;
         S_WRITE: wr_valid   = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_nvert      <= '0;
         r_base       <= '0;
         r_vcount     <= '0;
         r_remaining  <= '0;
         r_outdeg     <= '0;
         r_sum        <= '0;
         r_quot       <= '0;
         r_rem        <= '0;
         r_div_cnt    <= '0;
         r_wr_data    <= '0;
         r_round_done <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_round_done <= 1'b0;
         case (r_state)
            S_IDLE: if (start) begin
               r_nvert  <= n_vertices;
               r_base   <= base_waddr;
               r_vcount <= '0;
               r_err    <= 1'b0;
               if (n_vertices == '0) r_round_done <= 1'b1;
            end
            S_VERT: if (vert_valid) begin
               r_remaining <= vert_data[2*INT_W-1:INT_W];
               r_outdeg    <= vert_data[INT_W-1:0];
               r_sum       <= '0;
            end
            S_ACC: if (edge_valid) begin
               r_sum       <= w_acc;
               r_remaining <= w_rem_next;
               if (w_sat || w_excess) r_err <= 1'b1;
            end
            S_SCALE: begin
               r_quot    <= w_scaled;
               r_rem     <= '0;
               r_div_cnt <= CNT_W'(INT_W - 1);
               if (r_outdeg == '0) r_wr_data <= w_scaled;
            end
            S_DIV: begin
               r_quot    <= w_quot_new;
               r_rem     <= w_rem_new;
               r_div_cnt <= r_div_cnt - CNT_W'(1);
               if (r_div_cnt == '0) r_wr_data <= w_quot_new;
            end
            S_WRITE: if (wr_ready) begin
               r_vcount <= r_vcount + INT_W'(1);
               if (w_last) r_round_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign wr_addr      = r_base + (64'(r_vcount) * 64'(BYTES));
   assign wr_data      = r_wr_data;
   assign round_done   = r_round_done;
   assign err_overflow = r_err;

endmodule

// File: tb/tb_pr_vertex_engine.sv
// Directed bench for pr_vertex_engine: stimulus pushes expected writes into a
// queue, a negedge monitor drives wr_ready and checks every presented write.
module tb_pr_vertex_engine;

   localparam int unsigned INT_W = 64;
   localparam int unsigned LANES = 4;
   localparam int          TMO   = 300;

   typedef struct packed {
      logic [63:0] addr;
      logic [63:0] data;
   } wr_t;

   logic clk;
   logic rst;
   logic start1, start0;
   logic [INT_W-1:0]       n_vertices;
   logic [63:0]            base_waddr;
   logic [INT_W-1:0]       damping, teleport;
   logic                   vert_valid;
   logic [2*INT_W-1:0]     vert_data;
   logic                   edge_valid;
   logic [LANES-1:0]       edge_mask;
   logic [LANES*INT_W-1:0] edge_data;
   logic                   wr_ready;

   logic vert_ready_1, edge_ready_1, wr_valid_1, busy_1, round_done_1, err_1;
   logic vert_ready_0, edge_ready_0, wr_valid_0, busy_0, round_done_0, err_0;
   logic [63:0]      wr_addr_1, wr_addr_0;
   logic [INT_W-1:0] wr_data_1, wr_data_0;

   logic m_vert_ready, m_edge_ready, m_wr_valid, m_busy, m_round_done, m_err;
   logic [63:0]      m_wr_addr;
   logic [INT_W-1:0] m_wr_data;

   bit  sel;
   int  checks, errors, rd_count, stall, stall_cnt;
   wr_t q[$];
   wr_t e;

   pr_vertex_engine #(.INT_W(INT_W), .FRAC_W(16), .LANES(LANES), .DAMP_EN(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .n_vertices(n_vertices), .base_waddr(base_waddr),
      .damping(damping), .teleport(teleport), .vert_valid(vert_valid), .vert_data(vert_data),
      .vert_ready(vert_ready_1), .edge_valid(edge_valid), .edge_mask(edge_mask),
      .edge_data(edge_data), .edge_ready(edge_ready_1), .wr_valid(wr_valid_1),
      .wr_addr(wr_addr_1), .wr_data(wr_data_1), .wr_ready(wr_ready), .busy(busy_1),
      .round_done(round_done_1), .err_overflow(err_1));

   pr_vertex_engine #(.INT_W(INT_W), .FRAC_W(16), .LANES(LANES), .DAMP_EN(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .n_vertices(n_vertices), .base_waddr(base_waddr),
      .damping(damping), .teleport(teleport), .vert_valid(vert_valid), .vert_data(vert_data),
      .vert_ready(vert_ready_0), .edge_valid(edge_valid), .edge_mask(edge_mask),
      .edge_data(edge_data), .edge_ready(edge_ready_0), .wr_valid(wr_valid_0),
      .wr_addr(wr_addr_0), .wr_data(wr_data_0), .wr_ready(wr_ready), .busy(busy_0),
      .round_done(round_done_0), .err_overflow(err_0));

   always_comb begin
      if (sel) begin
         m_vert_ready = vert_ready_1; m_edge_ready = edge_ready_1; m_wr_valid = wr_valid_1;
         m_busy = busy_1; m_round_done = round_done_1; m_err = err_1;
         m_wr_addr = wr_addr_1; m_wr_data = wr_data_1;
      end else begin
         m_vert_ready = vert_ready_0; m_edge_ready = edge_ready_0; m_wr_valid = wr_valid_0;
         m_busy = busy_0; m_round_done = round_done_0; m_err = err_0;
         m_wr_addr = wr_addr_0; m_wr_data = wr_data_0;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Write monitor: drives wr_ready (with optional stall) and checks against the queue head
   initial begin
      forever begin
         @(negedge clk);
         if (m_round_done === 1'b1) rd_count++;
         if (m_wr_valid === 1'b1) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                        m_wr_addr, m_wr_data);
               wr_ready = 1'b1;
            end else begin
               e = q[0];
               chk("wr_addr", {64'h0, m_wr_addr}, {64'h0, e.addr});
               chk("wr_data", {64'h0, m_wr_data}, {64'h0, e.data});
               if (stall_cnt < stall) begin
                  wr_ready = 1'b0;
                  stall_cnt++;
               end else begin
                  wr_ready = 1'b1;
                  void'(q.pop_front());
                  stall_cnt = 0;
               end
            end
         end else begin
            wr_ready = 1'b0;
         end
      end
   end

   task automatic expect_wr(input logic [63:0] addr, input logic [63:0] data);
      wr_t t;
      t.addr = addr;
      t.data = data;
      q.push_back(t);
   endtask

   task automatic start_round(input logic [63:0] n, input logic [63:0] base);
      n_vertices = n;
      base_waddr = base;
      if (sel) start1 = 1'b1;
      else     start0 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      start0 = 1'b0;
   endtask

   task automatic send_vert(input logic [63:0] indeg, input logic [63:0] outdeg);
      bit ok;
      ok = 1'b0;
      vert_valid = 1'b1;
      vert_data  = {indeg, outdeg};
      for (int i = 0; i < TMO; i++) begin
         @(negedge clk);
         if (m_vert_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      vert_valid = 1'b0;
      chk("vert_handshake", {127'h0, ok}, 128'h1);
   endtask

   task automatic send_edge(input logic [LANES-1:0] mask, input logic [LANES*INT_W-1:0] data);
      bit ok;
      ok = 1'b0;
      edge_valid = 1'b1;
      edge_mask  = mask;
      edge_data  = data;
      for (int i = 0; i < TMO; i++) begin
         @(negedge clk);
         if (m_edge_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      edge_valid = 1'b0;
      chk("edge_handshake", {127'h0, ok}, 128'h1);
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < TMO && rd_count < target; i++) @(negedge clk);
      chk("round_done_count", 128'(rd_count), 128'(target));
      chk("queue_drained", 128'(q.size()), 128'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      checks = 0; errors = 0; rd_count = 0; stall = 0; stall_cnt = 0;
      sel = 1'b1;
      rst = 1'b1; start1 = 1'b0; start0 = 1'b0;
      n_vertices = '0; base_waddr = '0;
      damping = 64'h8000; teleport = 64'h1000;
      vert_valid = 1'b0; vert_data = '0;
      edge_valid = 1'b0; edge_mask = '0; edge_data = '0;
      wr_ready = 1'b0;

      repeat (3) @(posedge clk); #1;
      chk("reset_flags", {116'h0, vert_ready_1, edge_ready_1, wr_valid_1, busy_1, round_done_1,
          err_1, vert_ready_0, edge_ready_0, wr_valid_0, busy_0, round_done_0, err_0}, 128'h0);
      chk("reset_wr_addr", {wr_addr_1, wr_addr_0}, 128'h0);
      chk("reset_wr_data", {wr_data_1, wr_data_0}, 128'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // (3,2) with three lanes: ((0x60000*0.5)+0x1000)/2
      start_round(1, 64'h1000);
      expect_wr(64'h1000, 64'h18800);
      send_vert(3, 2);
      send_edge(4'b0111, {64'h0, 64'h30000, 64'h20000, 64'h10000});
      wait_done(1);
      chk("t1_err", {127'h0, m_err}, 128'h0);

      // Excess lane in second beat is dropped and flagged
      start_round(1, 64'h1000);
      expect_wr(64'h1000, 64'h29000);
      send_vert(5, 1);
      send_edge(4'b1111, {4{64'h10000}});
      send_edge(4'b0011, {64'h0, 64'h0, 64'h10000, 64'h10000});
      wait_done(2);
      chk("t2_err", {127'h0, m_err}, 128'h1);

      // Dangling vertex with no in-edges: teleport only, two cycles after handshake
      start_round(1, 64'h1000);
      expect_wr(64'h1000, 64'h1000);
      send_vert(0, 0);
      @(negedge clk);
      chk("t3_scale_cycle", {125'h0, m_edge_ready, m_wr_valid, m_busy}, 128'h1);
      @(negedge clk);
      chk("t3_latency", {127'h0, m_wr_valid}, 128'h1);
      wait_done(3);
      chk("t3_err", {127'h0, m_err}, 128'h0);

      // Undamped instance, three vertices, each write stalled five cycles
      sel = 1'b0;
      stall = 5;
      start_round(3, 64'h2000);
      for (int v = 0; v < 3; v++) begin
         expect_wr(64'h2000 + 64'(v * 8), 64'h7);
         send_vert(1, 1);
         send_edge(4'b0001, {64'h0, 64'h0, 64'h0, 64'h7});
      end
      wait_done(4);
      chk("t4_err", {127'h0, m_err}, 128'h0);
      stall = 0;

      // Saturating sum, then damping of all-ones: (2^64-1)>>1 + 0x1000
      sel = 1'b1;
      start_round(1, 64'h3000);
      expect_wr(64'h3000, 64'h8000_0000_0000_0FFF);
      send_vert(2, 1);
      send_edge(4'b0011, {64'h0, 64'h0, {64{1'b1}}, {64{1'b1}}});
      wait_done(5);
      chk("t5_err", {127'h0, m_err}, 128'h1);

      // Reset while dividing abandons the vertex
      start_round(1, 64'h4000);
      send_vert(1, 1);
      send_edge(4'b0001, {64'h0, 64'h0, 64'h0, 64'h10000});
      repeat (10) @(posedge clk); #1;
      chk("t6_in_div", {127'h0, m_busy}, 128'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t6_after_rst", {126'h0, m_busy, m_wr_valid}, 128'h0);
      repeat (100) @(negedge clk);
      chk("t6_no_round_done", 128'(rd_count), 128'h5);
      start_round(1, 64'h4000);
      expect_wr(64'h4000, 64'h9000);
      send_vert(1, 1);
      send_edge(4'b0001, {64'h0, 64'h0, 64'h0, 64'h10000});
      wait_done(6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
